// File: rtl/bp_pkg.sv
// Shared types, constants and the saturating-counter helper for the fetch-side
// branch predictor.
package bp_pkg;

  localparam int unsigned BTB_INDEX_W = 6;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Tag is held zero-extended to 32 bits so the view is independent of INDEX_W.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
    logic        is_jump;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Per-entry 2-bit saturating counter array: one read port for IF lookup,
// one read/write port at the EX index used for training.
module bp_sat_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_W = BTB_INDEX_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [INDEX_W-1:0] i_if_idx,
  output logic [1:0]         o_if_ctr,
  input  logic [INDEX_W-1:0] i_ex_idx,
  output logic [1:0]         o_ex_ctr,
  input  logic               i_wr_en,
  input  logic [1:0]         i_wr_ctr
);

  localparam int unsigned ENTRIES = 1 << INDEX_W;

  logic [1:0] ctr_q [ENTRIES];
  logic [1:0] ctr_d [ENTRIES];

  assign o_if_ctr = ctr_q[i_if_idx];
  assign o_ex_ctr = ctr_q[i_ex_idx];

  always_comb begin
    ctr_d = ctr_q;
    if (i_wr_en) ctr_d[i_ex_idx] = i_wr_ctr;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= ctr_d[i];
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational IF lookup, training from
// EX resolution, mispredict flagging and performance counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_W = BTB_INDEX_W,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_if_pc,
  output logic             o_pred_taken,
  output logic [31:0]      o_pred_pc,
  input  logic             i_ex_valid,
  input  logic [31:0]      i_ex_pc,
  input  logic             i_ex_is_branch,
  input  logic             i_ex_is_jump,
  input  logic             i_ex_taken,
  input  logic [31:0]      i_ex_target,
  input  logic             i_ex_pred_taken,
  input  logic [31:0]      i_ex_pred_pc,
  output logic             o_ex_mispredict,
  output logic [31:0]      o_ex_redirect_pc,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_miss_cnt
);

  localparam int unsigned ENTRIES = 1 << INDEX_W;
  localparam int unsigned TAG_W   = 30 - INDEX_W;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] is_jump_q, is_jump_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [INDEX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]   if_tag, ex_tag;
  logic [1:0]         if_ctr, ex_ctr;
  logic               if_hit, ex_hit;
  btb_entry_t         if_entry;
  logic               upd;
  logic               ctr_wr_en;
  logic [1:0]         ctr_wr;

  assign if_idx = i_if_pc[INDEX_W+1:2];
  assign if_tag = i_if_pc[31:INDEX_W+2];
  assign ex_idx = i_ex_pc[INDEX_W+1:2];
  assign ex_tag = i_ex_pc[31:INDEX_W+2];

  bp_sat_counter_table #(
    .INDEX_W (INDEX_W)
  ) u_ctr_table (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_if_idx (if_idx),
    .o_if_ctr (if_ctr),
    .i_ex_idx (ex_idx),
    .o_ex_ctr (ex_ctr),
    .i_wr_en  (ctr_wr_en),
    .i_wr_ctr (ctr_wr)
  );

  // Lookup reads only registered state, so a same-cycle write is not bypassed.
  always_comb begin
    if_entry.valid   = valid_q[if_idx];
    if_entry.tag     = {{(INDEX_W+2){1'b0}}, tag_q[if_idx]};
    if_entry.target  = target_q[if_idx];
    if_entry.ctr     = if_ctr;
    if_entry.is_jump = is_jump_q[if_idx];
    if_hit       = if_entry.valid && (if_entry.tag == {{(INDEX_W+2){1'b0}}, if_tag});
    o_pred_taken = if_hit && (if_entry.is_jump || (if_entry.ctr >= CTR_WT));
    o_pred_pc    = o_pred_taken ? if_entry.target : i_if_pc + 32'd4;
  end

  assign upd    = i_ex_valid && (i_ex_is_branch || i_ex_is_jump);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign o_ex_mispredict  = upd && ((i_ex_taken != i_ex_pred_taken) ||
                                    (i_ex_taken && (i_ex_pred_pc != i_ex_target)));
  assign o_ex_redirect_pc = i_ex_taken ? i_ex_target : i_ex_pc + 32'd4;

  always_comb begin
    valid_d    = valid_q;
    is_jump_d  = is_jump_q;
    tag_d      = tag_q;
    target_d   = target_q;
    ctr_wr_en  = 1'b0;
    ctr_wr     = ex_ctr;
    br_cnt_d   = br_cnt_q + {{(CNT_W-1){1'b0}}, upd};
    miss_cnt_d = miss_cnt_q + {{(CNT_W-1){1'b0}}, o_ex_mispredict};
    if (upd) begin
      if (ex_hit) begin
        ctr_wr_en = 1'b1;
        if (i_ex_is_jump) begin
          ctr_wr            = CTR_ST;
          target_d[ex_idx]  = i_ex_target;
          is_jump_d[ex_idx] = 1'b1;
        end else begin
          ctr_wr = ctr_next(ex_ctr, i_ex_taken);
          if (i_ex_taken) target_d[ex_idx] = i_ex_target;
        end
      end else if (i_ex_taken) begin
        ctr_wr_en         = 1'b1;
        ctr_wr            = i_ex_is_jump ? CTR_ST : CTR_WT;
        valid_d[ex_idx]   = 1'b1;
        tag_d[ex_idx]     = ex_tag;
        target_d[ex_idx]  = i_ex_target;
        is_jump_d[ex_idx] = i_ex_is_jump;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q    <= '0;
      is_jump_q  <= '0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      is_jump_q  <= is_jump_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag/target payload is qualified by valid, so it needs no reset.
  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      tag_q[i]    <= tag_d[i];
      target_q[i] <= target_d[i];
    end
  end

  assign o_br_cnt   = br_cnt_q;
  assign o_miss_cnt = miss_cnt_q;

  a_branch_xor_jump: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_ex_valid |-> !(i_ex_is_branch && i_ex_is_jump));

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_pc;
  logic        ex_mispredict;
  logic [31:0] ex_redirect_pc;
  logic [31:0] br_cnt, miss_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_br = 0;
  int unsigned exp_miss = 0;

  always #5 clk = ~clk;

  branch_predictor #(
    .INDEX_W (6),
    .CNT_W   (32)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_if_pc          (if_pc),
    .o_pred_taken     (pred_taken),
    .o_pred_pc        (pred_pc),
    .i_ex_valid       (ex_valid),
    .i_ex_pc          (ex_pc),
    .i_ex_is_branch   (ex_is_branch),
    .i_ex_is_jump     (ex_is_jump),
    .i_ex_taken       (ex_taken),
    .i_ex_target      (ex_target),
    .i_ex_pred_taken  (ex_pred_taken),
    .i_ex_pred_pc     (ex_pred_pc),
    .o_ex_mispredict  (ex_mispredict),
    .o_ex_redirect_pc (ex_redirect_pc),
    .o_br_cnt         (br_cnt),
    .o_miss_cnt       (miss_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ex_idle();
    ex_valid = 0; ex_pc = '0; ex_is_branch = 0; ex_is_jump = 0;
    ex_taken = 0; ex_target = '0; ex_pred_taken = 0; ex_pred_pc = '0;
  endtask

  task automatic ex_set(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                        input logic tk, input logic [31:0] tgt, input logic ppt,
                        input logic [31:0] ppc);
    ex_valid = v; ex_pc = pc; ex_is_branch = br; ex_is_jump = jmp;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = ppt; ex_pred_pc = ppc;
  endtask

  // Checks the combinational EX outputs, clocks once, then checks the counters.
  task automatic ex_commit(input string tag, input logic exp_mp, input logic [31:0] exp_redir);
    #1;
    check_eq({tag, ".mispredict"}, {31'd0, ex_mispredict}, {31'd0, exp_mp});
    check_eq({tag, ".redirect"}, ex_redirect_pc, exp_redir);
    if (ex_valid && (ex_is_branch || ex_is_jump)) exp_br++;
    if (exp_mp) exp_miss++;
    @(posedge clk); #1;
    ex_idle();
    check_eq({tag, ".br_cnt"}, br_cnt, exp_br);
    check_eq({tag, ".miss_cnt"}, miss_cnt, exp_miss);
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_tk,
                      input logic [31:0] exp_pc);
    if_pc = pc;
    #1;
    check_eq({tag, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
    check_eq({tag, ".pred_pc"}, pred_pc, exp_pc);
  endtask

  initial begin
    rst_n = 0;
    if_pc = 32'h100;
    ex_idle();
    look("reset", 32'h100, 0, 32'h104);
    check_eq("reset.br_cnt", br_cnt, 0);
    check_eq("reset.miss_cnt", miss_cnt, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    look("wrap", 32'hFFFF_FFFC, 0, 32'h0000_0000);

    // Cold taken beq with lookup of the same PC in the same cycle
    ex_set(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    look("same_cycle", 32'h100, 0, 32'h104);
    ex_commit("cold", 1, 32'h80);
    look("alloc", 32'h100, 1, 32'h80);                 // ctr=10

    ex_set(1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
    ex_commit("nt1", 1, 32'h104);
    look("ctr01", 32'h100, 0, 32'h104);                // ctr=01
    ex_set(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    ex_commit("t1", 1, 32'h80);
    look("ctr10", 32'h100, 1, 32'h80);                 // ctr=10
    for (int i = 0; i < 3; i++) begin
      ex_set(1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80);
      ex_commit("t_sat", 0, 32'h80);
    end
    look("ctr11", 32'h100, 1, 32'h80);
    ex_set(1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
    ex_commit("nt_from11", 1, 32'h104);
    look("sat_hi", 32'h100, 1, 32'h80);                // 11 -> 10, still taken
    ex_set(1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
    ex_commit("nt_to01", 1, 32'h104);
    look("ctr01b", 32'h100, 0, 32'h104);
    for (int i = 0; i < 2; i++) begin
      ex_set(1, 32'h100, 1, 0, 0, 32'h80, 0, 32'h104);
      ex_commit("nt_sat", 0, 32'h104);
    end
    ex_set(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    ex_commit("t_from00", 1, 32'h80);
    look("sat_lo", 32'h100, 0, 32'h104);               // 00 -> 01, still not taken
    ex_set(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    ex_commit("t_to10", 1, 32'h80);
    look("ctr10b", 32'h100, 1, 32'h80);

    // Wrong target on a taken prediction
    ex_set(1, 32'h100, 1, 0, 1, 32'h90, 1, 32'h80);
    ex_commit("bad_tgt", 1, 32'h90);
    look("new_tgt", 32'h100, 1, 32'h90);

    // Aliasing jal at 0x100 + (4<<6) = 0x200 maps to the same index
    ex_set(1, 32'h200, 0, 1, 1, 32'h200, 0, 32'h204);
    ex_commit("alias", 1, 32'h200);
    look("alias_old", 32'h100, 0, 32'h104);
    look("alias_new", 32'h200, 1, 32'h200);

    // Non-updates
    ex_set(0, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    ex_commit("bubble", 0, 32'h80);
    look("bubble_noalloc", 32'h100, 0, 32'h104);
    ex_set(1, 32'h300, 0, 0, 0, 32'h0, 0, 32'h304);
    ex_commit("alu", 0, 32'h304);
    ex_set(1, 32'h400, 1, 0, 0, 32'h480, 0, 32'h404);
    ex_commit("nt_miss", 0, 32'h404);
    look("nt_noalloc", 32'h400, 0, 32'h404);
    look("occupant_kept", 32'h200, 1, 32'h200);

    // Jump hit retrains target
    ex_set(1, 32'h200, 0, 1, 1, 32'h240, 1, 32'h200);
    ex_commit("jalr_hit", 1, 32'h240);
    look("jalr_tgt", 32'h200, 1, 32'h240);

    // Reset mid-operation with an update in flight
    ex_set(1, 32'h200, 0, 1, 1, 32'h300, 1, 32'h240);
    rst_n = 0;
    look("midrst", 32'h200, 0, 32'h204);
    check_eq("midrst.br_cnt", br_cnt, 0);
    check_eq("midrst.miss_cnt", miss_cnt, 0);
    @(posedge clk); #1;
    ex_idle();
    rst_n = 1;
    @(posedge clk); #1;
    look("post_rst", 32'h200, 0, 32'h204);
    check_eq("post_rst.br_cnt", br_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
